decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_pkg.sv | 56 +++++
 rtl/imm_gen.sv | 17 +
 rtl/decode_stage.sv | 189 ++++++++++++++++++
 tb/tb_decode_stage.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared RV32I decode constants, execute operation codes and the decoded-bundle type.
package decode_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned OP_W  = 5;
   localparam int unsigned REG_W = 5;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   localparam logic [OP_W-1:0] OPN_ADD  = 5'b00000;
   localparam logic [OP_W-1:0] OPN_SUB  = 5'b01000;
   localparam logic [OP_W-1:0] OPN_SLL  = 5'b00001;
   localparam logic [OP_W-1:0] OPN_SLT  = 5'b00010;
   localparam logic [OP_W-1:0] OPN_SLTU = 5'b00110;
   localparam logic [OP_W-1:0] OPN_XOR  = 5'b00100;
   localparam logic [OP_W-1:0] OPN_SRL  = 5'b00101;
   localparam logic [OP_W-1:0] OPN_SRA  = 5'b01101;
   localparam logic [OP_W-1:0] OPN_OR   = 5'b00011;
   localparam logic [OP_W-1:0] OPN_AND  = 5'b00111;
   localparam logic [OP_W-1:0] OPN_LUI  = 5'b11000;
   localparam logic [OP_W-1:0] OPN_JALR = 5'b11001;
   localparam logic [1:0]      OPN_BR   = 2'b10;

   typedef struct packed {
      logic [OP_W-1:0]  operation;
      logic [XLEN-1:0]  operand1;
      logic [XLEN-1:0]  operand2;
      logic [XLEN-1:0]  imm;
      logic [XLEN-1:0]  pc;
      logic [REG_W-1:0] rd;
      logic             rd_we;
      logic             illegal;
   } dec_bundle_t;

   // funct3 -> ALU code; alt is funct7[5], sub_ok only for register-register ops
   function automatic logic [OP_W-1:0] alu_op(input logic [2:0] funct3, input logic alt,
                                              input logic sub_ok);
      case (funct3)
         3'b000:  alu_op = (alt && sub_ok) ? OPN_SUB : OPN_ADD;
         3'b001:  alu_op = OPN_SLL;
         3'b010:  alu_op = OPN_SLT;
         3'b011:  alu_op = OPN_SLTU;
         3'b100:  alu_op = OPN_XOR;
         3'b101:  alu_op = alt ? OPN_SRA : OPN_SRL;
         3'b110:  alu_op = OPN_OR;
         default: alu_op = OPN_AND;
      endcase
   endfunction

endpackage

// File: rtl/imm_gen.sv
// RV32I immediate extraction (I/S/B/U formats); the opcode field is not needed here.
module imm_gen
   import decode_pkg::*;
(
   input  logic [31:7]     instr,
   output logic [XLEN-1:0] imm_i,
   output logic [XLEN-1:0] imm_s,
   output logic [XLEN-1:0] imm_b,
   output logic [XLEN-1:0] imm_u
);

   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {instr[31:12], 12'b0};

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage with a one-entry registered output bundle.
// Optional register busy scoreboard enabled by defining DECODE_SCOREBOARD_EN.
module decode_stage
   import decode_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   input  logic [31:0] in_pc,
   output logic [4:0]  rs1_addr,
   output logic [4:0]  rs2_addr,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   input  logic        wb_valid,
   input  logic [4:0]  wb_rd,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [4:0]  out_operation,
   output logic [31:0] out_operand1,
   output logic [31:0] out_operand2,
   output logic [31:0] out_imm,
   output logic [31:0] out_pc,
   output logic [4:0]  out_rd,
   output logic        out_rd_we,
   output logic        out_illegal
);

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u;
   dec_bundle_t     dec_c;
   logic            writes_rd_c;
   logic            hazard_c;
   logic            accept_c;
   dec_bundle_t     bundle_q, bundle_d;
   logic            valid_q, valid_d;

   assign opcode   = in_instr[6:0];
   assign funct3   = in_instr[14:12];
   assign funct7   = in_instr[31:25];
   assign rs1_addr = in_instr[19:15];
   assign rs2_addr = in_instr[24:20];

   imm_gen u_imm_gen (
      .instr (in_instr[31:7]),
      .imm_i (imm_i),
      .imm_s (imm_s),
      .imm_b (imm_b),
      .imm_u (imm_u)
   );

   // Combinational decode of the presented instruction
   always_comb begin
      dec_c          = '0;
      writes_rd_c    = 1'b0;
      dec_c.pc       = in_pc;
      dec_c.rd       = in_instr[11:7];
      dec_c.operand1 = rs1_data;
      dec_c.operand2 = rs2_data;
      dec_c.operation = OPN_ADD;
      case (opcode)
         OPC_OP: begin
            dec_c.operation = alu_op(funct3, funct7[5], 1'b1);
            writes_rd_c     = 1'b1;
         end
         OPC_OP_IMM: begin
            dec_c.operation = alu_op(funct3, funct7[5], 1'b0);
            dec_c.operand2  = imm_i;
            if (funct3 == 3'b001 || funct3 == 3'b101) begin
               dec_c.operand2 = XLEN'(in_instr[24:20]);
               dec_c.illegal  = (funct7 & 7'b1011111) != 7'b0;
            end
            dec_c.imm   = dec_c.operand2;
            writes_rd_c = 1'b1;
         end
         OPC_LOAD: begin
            dec_c.operand2 = imm_i;
            dec_c.imm      = imm_i;
            writes_rd_c    = 1'b1;
         end
         OPC_STORE: begin
            dec_c.operand2 = imm_s;
            dec_c.imm      = imm_s;
         end
         OPC_BRANCH: begin
            dec_c.operation = {OPN_BR, funct3};
            dec_c.imm       = imm_b;
            dec_c.illegal   = (funct3 == 3'b010) || (funct3 == 3'b011);
         end
         OPC_LUI: begin
            dec_c.operation = OPN_LUI;
            dec_c.operand1  = '0;
            dec_c.operand2  = imm_u;
            dec_c.imm       = imm_u;
            writes_rd_c     = 1'b1;
         end
         OPC_JALR: begin
            dec_c.operation = OPN_JALR;
            dec_c.operand2  = imm_i;
            dec_c.imm       = imm_i;
            writes_rd_c     = 1'b1;
         end
         default: dec_c.illegal = 1'b1;
      endcase
      if (dec_c.illegal) begin
         dec_c.operation = OPN_ADD;
         dec_c.rd_we     = 1'b0;
      end else begin
         dec_c.rd_we = writes_rd_c && (dec_c.rd != '0);
      end
   end

   // Flush kills both the held bundle and any simultaneous accept
   assign in_ready = (~valid_q | out_ready) & ~hazard_c & ~flush;
   assign accept_c = in_valid & in_ready;

   always_comb begin
      bundle_d = bundle_q;
      valid_d  = valid_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (accept_c) begin
         bundle_d = dec_c;
         valid_d  = 1'b1;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bundle_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         bundle_q <= bundle_d;
         valid_q  <= valid_d;
      end
   end

`ifdef DECODE_SCOREBOARD_EN
   logic [31:0] busy_q, busy_d;
   logic        rs1_used_c, rs2_used_c;
   logic        rs1_busy_c, rs2_busy_c;

   assign rs1_used_c = (opcode == OPC_OP) || (opcode == OPC_OP_IMM) || (opcode == OPC_LOAD) ||
                       (opcode == OPC_STORE) || (opcode == OPC_BRANCH) || (opcode == OPC_JALR);
   assign rs2_used_c = (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);

   // The held bundle's rd is already marked busy; matching it explicitly keeps intent obvious
   assign rs1_busy_c = busy_q[rs1_addr] ||
                       (valid_q && bundle_q.rd_we && (bundle_q.rd == rs1_addr));
   assign rs2_busy_c = busy_q[rs2_addr] ||
                       (valid_q && bundle_q.rd_we && (bundle_q.rd == rs2_addr));
   assign hazard_c   = (rs1_used_c && rs1_busy_c) || (rs2_used_c && rs2_busy_c);

   // Clears first so a same-cycle set on the same register wins
   always_comb begin
      busy_d = busy_q;
      if (wb_valid) busy_d[wb_rd] = 1'b0;
      if (flush && valid_q && bundle_q.rd_we) busy_d[bundle_q.rd] = 1'b0;
      if (accept_c && dec_c.rd_we) busy_d[dec_c.rd] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy_q <= '0;
      else        busy_q <= busy_d;
   end
`else
   logic unused_wb;
   assign hazard_c  = 1'b0;
   assign unused_wb = ^{wb_valid, wb_rd};
`endif

   assign out_valid     = valid_q;
   assign out_operation = bundle_q.operation;
   assign out_operand1  = bundle_q.operand1;
   assign out_operand2  = bundle_q.operand2;
   assign out_imm       = bundle_q.imm;
   assign out_pc        = bundle_q.pc;
   assign out_rd        = bundle_q.rd;
   assign out_rd_we     = bundle_q.rd_we;
   assign out_illegal   = bundle_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: vector table through a scoreboard queue plus
// hand-written stall, flush, reset and hazard sequences (hazard path needs DECODE_SCOREBOARD_EN).
`timescale 1ns/1ps
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic [31:0] in_instr, in_pc;
   logic [4:0]  rs1_addr, rs2_addr;
   logic [31:0] rs1_data, rs2_data;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic        flush;
   logic        out_valid, out_ready;
   logic [4:0]  out_operation;
   logic [31:0] out_operand1, out_operand2, out_imm, out_pc;
   logic [4:0]  out_rd;
   logic        out_rd_we, out_illegal;

   decode_stage dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .wb_valid(wb_valid), .wb_rd(wb_rd),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .out_operation(out_operation), .out_operand1(out_operand1),
      .out_operand2(out_operand2), .out_imm(out_imm), .out_pc(out_pc), .out_rd(out_rd),
      .out_rd_we(out_rd_we), .out_illegal(out_illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr, pc, d1, d2;
      logic [4:0]  op;
      logic [31:0] op1, op2, imm;
      logic        cmp_imm;
      logic [4:0]  rd;
      logic        we, ill;
      int          cyc;
   } vec_t;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   vec_t sb_q[$];
   vec_t vecs[15];
   vec_t cur, last, hold_v;
   logic accepted = 1'b0;
   logic hold_chk = 1'b0, expect_stall = 1'b0, auto_wb = 1'b1, lat_chk = 1'b1;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] d1,
                               input logic [31:0] d2, input logic [4:0] op,
                               input logic [31:0] op1, input logic [31:0] op2,
                               input logic [31:0] imm, input logic cmp_imm,
                               input logic [4:0] rd, input logic we, input logic ill);
      vec_t v;
      v.instr = instr; v.pc = 32'h0; v.d1 = d1; v.d2 = d2; v.op = op;
      v.op1 = op1; v.op2 = op2; v.imm = imm; v.cmp_imm = cmp_imm;
      v.rd = rd; v.we = we; v.ill = ill; v.cyc = 0;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // One clock: sample at negedge (check, pop, accept/push), then drive at posedge+1
   task automatic tick();
      vec_t e;
      logic [31:0] ins;
      @(negedge clk);
      if (hold_chk) begin
         chk("hold_valid", 32'(out_valid), 32'd1);
         chk("hold_op", 32'(out_operation), 32'(hold_v.op));
         chk("hold_operand1", out_operand1, hold_v.op1);
         chk("hold_operand2", out_operand2, hold_v.op2);
         chk("hold_pc", out_pc, hold_v.pc);
         chk("hold_rd", 32'(out_rd), 32'(hold_v.rd));
      end
      if (hold_chk || expect_stall) chk("stall_in_ready", 32'(in_ready), 32'd0);
      if (out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_output: got pc 0x%08h expected no bundle", out_pc);
         end else begin
            e = sb_q.pop_front();
            chk($sformatf("op[%08h]", e.instr), 32'(out_operation), 32'(e.op));
            chk($sformatf("illegal[%08h]", e.instr), 32'(out_illegal), 32'(e.ill));
            chk($sformatf("rd_we[%08h]", e.instr), 32'(out_rd_we), 32'(e.we));
            chk($sformatf("pc[%08h]", e.instr), out_pc, e.pc);
            if (!e.ill) begin
               chk($sformatf("operand1[%08h]", e.instr), out_operand1, e.op1);
               chk($sformatf("operand2[%08h]", e.instr), out_operand2, e.op2);
            end
            if (e.cmp_imm) chk($sformatf("imm[%08h]", e.instr), out_imm, e.imm);
            if (e.we) chk($sformatf("rd[%08h]", e.instr), 32'(out_rd), 32'(e.rd));
            if (lat_chk) chk($sformatf("latency[%08h]", e.instr), 32'(cyc - e.cyc), 32'd1);
         end
      end
      accepted = in_valid && in_ready;
      if (accepted) begin
         ins = cur.instr;
         chk("rs1_addr", 32'(rs1_addr), 32'(ins[19:15]));
         chk("rs2_addr", 32'(rs2_addr), 32'(ins[24:20]));
         e = cur; e.cyc = cyc;
         sb_q.push_back(e);
         last = cur;
      end
      @(posedge clk); #1;
      wb_valid = auto_wb && accepted && last.we;
      wb_rd    = last.rd;
   endtask

   task automatic present(input vec_t v);
      cur = v; in_valid = 1'b1; in_instr = v.instr; in_pc = v.pc;
      rs1_data = v.d1; rs2_data = v.d2;
   endtask

   task automatic issue(input vec_t v);
      int n = 0;
      present(v);
      do begin tick(); n++; end while (!accepted && n < 20);
      if (!accepted) begin
         n_checks++; n_fail++;
         $display("FAIL accept_timeout: got no accept of 0x%08h expected accept", v.instr);
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb_q.size() != 0 && n < 10) begin tick(); n++; end
      chk("drain_empty", 32'(sb_q.size()), 32'd0);
   endtask

   initial begin
      vec_t a, b;
      rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; rs1_data = '0;
      rs2_data = '0; wb_valid = 1'b0; wb_rd = '0; flush = 1'b0; out_ready = 1'b1;

      vecs[0]  = mk(32'h002081B3, 5, 7, 5'b00000, 5, 7, 0, 0, 3, 1, 0);          // add x3,x1,x2
      vecs[1]  = mk(32'h407302B3, 20, 3, 5'b01000, 20, 3, 0, 0, 5, 1, 0);        // sub x5,x6,x7
      vecs[2]  = mk(32'h00208463, 1, 1, 5'b10000, 1, 1, 8, 1, 0, 0, 0);          // beq +8
      vecs[3]  = mk(32'h123450B7, 99, 4, 5'b11000, 0, 32'h12345000, 32'h12345000, 1, 1, 1, 0);
      vecs[4]  = mk(32'hFFFFFFFF, 0, 0, 5'b00000, 0, 0, 0, 0, 0, 0, 1);
      vecs[5]  = mk(32'hFFF10213, 10, 0, 5'b00000, 10, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 4, 1, 0);
      vecs[6]  = mk(32'h4033D313, 32'h80, 0, 5'b01101, 32'h80, 3, 0, 0, 6, 1, 0); // srai
      vecs[7]  = mk(32'h02109093, 0, 0, 5'b00000, 0, 0, 0, 0, 0, 0, 1);         // slli bad funct7
      vecs[8]  = mk(32'h0020A623, 100, 9, 5'b00000, 100, 12, 12, 1, 0, 0, 0);   // sw
      vecs[9]  = mk(32'h0040A003, 50, 0, 5'b00000, 50, 4, 4, 1, 0, 0, 0);       // lw x0
      vecs[10] = mk(32'hFFC280E7, 32'h1000, 0, 5'b11001, 32'h1000, 32'hFFFFFFFC,
                    32'hFFFFFFFC, 1, 1, 1, 0);                                     // jalr
      vecs[11] = mk(32'hFE41FCE3, 3, 4, 5'b10111, 3, 4, 32'hFFFFFFF8, 1, 0, 0, 0); // bgeu -8
      vecs[12] = mk(32'h00002063, 0, 0, 5'b00000, 0, 0, 0, 0, 0, 0, 1);         // branch f3=010
      vecs[13] = mk(32'h009463B3, 32'hF0, 32'h0F, 5'b00011, 32'hF0, 32'h0F, 0, 0, 7, 1, 0);
      vecs[14] = mk(32'h0054B413, 9, 0, 5'b00110, 9, 5, 5, 1, 8, 1, 0);          // sltiu

      repeat (2) @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_illegal", 32'(out_illegal), 32'd0);
      chk("rst_out_rd_we", 32'(out_rd_we), 32'd0);
      chk("rst_out_operation", 32'(out_operation), 32'd0);
      chk("rst_out_operand1", out_operand1, 32'd0);
      chk("rst_out_operand2", out_operand2, 32'd0);
      chk("rst_out_imm", out_imm, 32'd0);
      chk("rst_out_pc", out_pc, 32'd0);
      chk("rst_out_rd", 32'(out_rd), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      for (int i = 0; i < 15; i++) begin
         vecs[i].pc = 32'h100 + 32'(i) * 4;
         issue(vecs[i]);
      end
      drain();

      // Output held for 3 cycles of back-pressure, then released together with a new accept
      a = vecs[0]; a.pc = 32'h400;
      b = vecs[1]; b.pc = 32'h404;
      lat_chk = 1'b0;
      issue(a);
      present(b);
      out_ready = 1'b0; hold_v = a; hold_chk = 1'b1;
      repeat (3) tick();
      hold_chk = 1'b0; out_ready = 1'b1;
      tick();
      chk("stall_release_accept", 32'(accepted), 32'd1);
      in_valid = 1'b0;
      drain();
      lat_chk = 1'b1;

      // Flush kills the held bundle and blocks the simultaneous accept
      a.pc = 32'h500;
      issue(a);
      present(b);
      flush = 1'b1; out_ready = 1'b0; expect_stall = 1'b1;
      tick();
      expect_stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      chk("flush_dropped", 32'(accepted), 32'd0);
      if (sb_q.size() != 0) void'(sb_q.pop_front());
      out_ready = 1'b1;
      repeat (2) tick();
      chk("flush_no_output", 32'(sb_q.size()), 32'd0);

      // Reset while a bundle is held
      a.pc = 32'h600;
      issue(a);
      out_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_out_operand1", out_operand1, 32'd0);
      sb_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1; out_ready = 1'b1;

      // RAW dependency: addi x1,x0,1 then add x2,x1,x1
      a = mk(32'h00100093, 0, 0, 5'b00000, 0, 1, 1, 1, 1, 1, 0);
      b = mk(32'h00108133, 1, 1, 5'b00000, 1, 1, 0, 0, 2, 1, 0);
      a.pc = 32'h700; b.pc = 32'h704;
      auto_wb = 1'b0;
`ifdef DECODE_SCOREBOARD_EN
      issue(a);
      present(b);
      expect_stall = 1'b1;
      repeat (4) tick();
      wb_valid = 1'b1; wb_rd = 5'd1;
      tick();
      expect_stall = 1'b0; auto_wb = 1'b1;
      tick();
      chk("hazard_release_accept", 32'(accepted), 32'd1);
`else
      issue(a);
      present(b);
      tick();
      chk("no_hazard_accept", 32'(accepted), 32'd1);
`endif
      in_valid = 1'b0; auto_wb = 1'b1;
      drain();

      repeat (2) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
